// File: rtl/nes_bus_pkg.sv
// rtl/nes_bus_pkg.sv - shared CPU bus constants and sprite DMA state type
package nes_bus_pkg;

   typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} dma_state_t;

   // CPU write to this address starts a sprite DMA from page cpuDataOut
   localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
   // Every DMA write lands on OAMDATA
   localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;
   // System clocks per CPU cycle
   localparam int          CPU_CLK_DIV   = 12;
   // Bytes per DMA; the 8-bit idx counter relies on this being 256
   localparam int          XFER_LEN      = 256;

endpackage

// File: rtl/oam_dma_controller.sv
// rtl/oam_dma_controller.sv - CPU bus owner that halts the CPU for sprite DMA to OAMDATA
module oam_dma_controller
   import nes_bus_pkg::*;
(
   input  logic        clock,
   input  logic        reset,
   input  logic        cpuTick,
   input  logic [15:0] cpuAddress,
   input  logic [7:0]  cpuDataOut,
   input  logic        cpuRw,
   input  logic [7:0]  busDataIn,
   output logic [15:0] busAddress,
   output logic [7:0]  busDataOut,
   output logic        busRw,
   output logic        cpuHalt,
   output logic        dmaActive,
   output logic        dmaDone
);

   dma_state_t  state;
   dma_state_t  next_state;
   logic [7:0]  page;
   logic [7:0]  idx;
   logic [7:0]  latch;
   logic        parity;
   logic        halt_q;
   logic        done_q;
   logic        trigger;

   // A CPU write to the DMA register; only acted on while IDLE
   assign trigger = (cpuAddress == DMA_REG_ADDR) && !cpuRw;

   assign cpuHalt   = halt_q;
   assign dmaActive = halt_q;
   assign dmaDone   = done_q;

   // State, counters and parity advance only on CPU ticks; done is a single-clock pulse
   always_ff @(posedge clock) begin
      if (!reset) begin
         state  <= IDLE;
         page   <= 8'h00;
         idx    <= 8'h00;
         latch  <= 8'h00;
         parity <= 1'b0;
         halt_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (cpuTick) begin
            state  <= next_state;
            parity <= ~parity;
            halt_q <= (next_state != IDLE);
            if (state == IDLE && trigger) begin
               page <= cpuDataOut;
               idx  <= 8'h00;
            end
            if (state == READ) begin
               latch <= busDataIn;
            end
            if (state == WRITE) begin
               // idx wraps FF->00 on the final write, leaving it clean for the next DMA
               idx <= idx + 8'h01;
               if (idx == 8'hFF) begin
                  done_q <= 1'b1;
               end
            end
         end
      end
   end

   // Next-state selection and bus steering; CPU passes through unless DMA owns the cycle
   always_comb begin
      next_state = state;
      busAddress = cpuAddress;
      busDataOut = cpuDataOut;
      busRw      = cpuRw;
      case (state)
         IDLE: begin
            if (trigger) begin
               next_state = HALT;
            end
         end
         HALT: begin
            busRw = 1'b1;
            // parity 0 here means the next cycle is odd, so burn one more to start READ even
            next_state = parity ? READ : ALIGN;
         end
         ALIGN: begin
            busRw      = 1'b1;
            next_state = READ;
         end
         READ: begin
            busAddress = {page, idx};
            busRw      = 1'b1;
            next_state = WRITE;
         end
         WRITE: begin
            busAddress = OAM_DATA_ADDR;
            busDataOut = latch;
            busRw      = 1'b0;
            next_state = (idx == 8'hFF) ? IDLE : READ;
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_oam_dma_controller.sv
// tb/tb_oam_dma_controller.sv - self-checking bench for oam_dma_controller
module tb_oam_dma_controller;

   localparam int DIV = 12;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        cpuTick = 1'b0;
   logic [15:0] cpuAddress = 16'h0000;
   logic [7:0]  cpuDataOut = 8'h00;
   logic        cpuRw = 1'b1;
   logic [7:0]  busDataIn;
   logic [15:0] busAddress;
   logic [7:0]  busDataOut;
   logic        busRw;
   logic        cpuHalt;
   logic        dmaActive;
   logic        dmaDone;

   int checks = 0;
   int errors = 0;

   logic [7:0] mem [0:65535];
   assign busDataIn = mem[busAddress];

   oam_dma_controller dut (
      .clock      (clock),
      .reset      (reset),
      .cpuTick    (cpuTick),
      .cpuAddress (cpuAddress),
      .cpuDataOut (cpuDataOut),
      .cpuRw      (cpuRw),
      .busDataIn  (busDataIn),
      .busAddress (busAddress),
      .busDataOut (busDataOut),
      .busRw      (busRw),
      .cpuHalt    (cpuHalt),
      .dmaActive  (dmaActive),
      .dmaDone    (dmaDone)
   );

   always #5 clock = ~clock;

   // divide-by-12 CPU tick, suppressible for the gating test
   bit tick_en = 1'b1;
   int div = 0;
   initial begin
      forever begin
         @(posedge clock);
         #1;
         div = (div == DIV - 1) ? 0 : div + 1;
         cpuTick = tick_en && (div == DIV - 1);
      end
   end

   // behavioural model: count halted CPU cycles since the trigger
   bit         m_active = 1'b0;
   bit         m_done = 1'b0;
   bit         m_parity = 1'b0;
   logic [7:0] m_page = 8'h00;
   int         m_k = 0;
   int         m_lead = 1;
   always @(posedge clock) begin
      if (!reset) begin
         m_active = 1'b0;
         m_done   = 1'b0;
         m_parity = 1'b0;
         m_k      = 0;
      end else begin
         m_done = 1'b0;
         if (cpuTick) begin
            if (m_active) begin
               m_k = m_k + 1;
               if (m_k == m_lead + 512) begin
                  m_active = 1'b0;
                  m_done   = 1'b1;
               end
            end else if (cpuAddress == 16'h4014 && !cpuRw) begin
               m_active = 1'b1;
               m_page   = cpuDataOut;
               m_k      = 0;
               m_lead   = m_parity ? 2 : 1;
            end
            m_parity = ~m_parity;
         end
      end
   end

   // observed DMA statistics
   int         halt_ticks = 0;
   int         done_pulses = 0;
   logic [7:0] oam_q [$];
   always @(posedge clock) begin
      if (cpuTick && cpuHalt) halt_ticks++;
      if (dmaDone) done_pulses++;
      if (cpuTick && cpuHalt && !busRw && busAddress == 16'h2004) oam_q.push_back(busDataOut);
   end

   // per-cycle comparison against the model
   bit          chk_en = 1'b0;
   logic [15:0] e_addr;
   logic        e_rw;
   logic [7:0]  e_data;
   bit          e_dchk;
   int          e_j;
   bit          ok;
   always @(negedge clock) begin
      if (chk_en) begin
         e_dchk = 1'b0;
         e_data = 8'h00;
         if (!m_active) begin
            e_addr = cpuAddress;
            e_rw   = cpuRw;
            e_data = cpuDataOut;
            e_dchk = 1'b1;
         end else if (m_k < m_lead) begin
            e_addr = cpuAddress;
            e_rw   = 1'b1;
         end else begin
            e_j = m_k - m_lead;
            if (e_j % 2 == 0) begin
               e_addr = {m_page, 8'(e_j / 2)};
               e_rw   = 1'b1;
            end else begin
               e_addr = 16'h2004;
               e_rw   = 1'b0;
               e_data = mem[{m_page, 8'(e_j / 2)}];
               e_dchk = 1'b1;
            end
         end
         ok = (cpuHalt === m_active) && (dmaActive === m_active) && (dmaDone === m_done) &&
              (busAddress === e_addr) && (busRw === e_rw) && (!e_dchk || busDataOut === e_data);
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL cycle t=%0t halt=%b act=%b req=%b done=%b req=%b addr=%h req=%h rw=%b req=%b data=%h req=%h",
                     $time, cpuHalt, dmaActive, m_active, dmaDone, m_done, busAddress, e_addr, busRw, e_rw, busDataOut, e_data);
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   task automatic drive(input logic [15:0] a, input logic [7:0] d, input logic rw);
      cpuAddress = a;
      cpuDataOut = d;
      cpuRw      = rw;
   endtask

   task automatic wait_tick();
      int n = 0;
      do begin
         @(posedge clock);
         n++;
      end while (!cpuTick && n < 100);
      if (!cpuTick) check("tick_timeout", 1, 0);
      #2;
   endtask

   task automatic idle_cycle();
      drive(16'h0000, 8'h00, 1'b1);
      wait_tick();
   endtask

   task automatic start_dma(input logic [7:0] pg, input bit par);
      int n = 0;
      while (m_parity != par && n < 4) begin
         idle_cycle();
         n++;
      end
      halt_ticks  = 0;
      done_pulses = 0;
      oam_q.delete();
      drive(16'h4014, pg, 1'b0);
      wait_tick();
      drive(16'h8123, 8'hC3, 1'b1);
   endtask

   task automatic wait_k(input int k);
      int n = 0;
      while (!(m_active && m_k == k) && n < 10000) begin
         @(posedge clock);
         #2;
         n++;
      end
      if (n >= 10000) check("wait_k_timeout", 1, 0);
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(posedge clock);
         #2;
         n++;
      end while ((m_active || dmaActive) && n < 10000);
      if (n >= 10000) check("idle_timeout", 1, 0);
      repeat (2) @(posedge clock);
      #2;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int a = 0; a < 65536; a++) begin
         mem[a] = 8'(a) ^ 8'h5A ^ (8'(a >> 8) - 8'h03);
      end
      drive(16'h1234, 8'h77, 1'b1);
      reset = 1'b0;
      repeat (3) @(posedge clock);
      #2;
      chk_en = 1'b1;
      check("reset_halt", cpuHalt, 0);
      check("reset_active", dmaActive, 0);
      check("reset_done", dmaDone, 0);
      check("reset_bus_addr", busAddress, 16'h1234);
      reset = 1'b1;

      // page 02 triggered on an even cycle
      start_dma(8'h02, 1'b0);
      wait_idle();
      check("even_halt_ticks", halt_ticks, 513);
      check("even_done_pulses", done_pulses, 1);
      check("even_oam_count", oam_q.size(), 256);
      check("even_first_byte", oam_q[0], 8'hA5);

      // page 02 triggered on an odd cycle, with ticks gated mid-transfer
      start_dma(8'h02, 1'b1);
      wait_k(200);
      tick_en = 1'b0;
      repeat (100) @(posedge clock);
      #2;
      check("gated_still_active", dmaActive, 1);
      tick_en = 1'b1;
      wait_idle();
      check("odd_halt_ticks", halt_ticks, 514);
      check("odd_done_pulses", done_pulses, 1);
      check("odd_oam_count", oam_q.size(), 256);

      // page 03 data integrity
      start_dma(8'h03, 1'b0);
      wait_idle();
      check("p3_oam_count", oam_q.size(), 256);
      check("p3_byte0", oam_q[0], 8'h5A);
      check("p3_byte1", oam_q[1], 8'h5B);
      check("p3_byte2", oam_q[2], 8'h58);
      check("p3_byte255", oam_q[255], 8'hA5);

      // reset during READ of idx 40, with a trigger while reset is held
      start_dma(8'h02, 1'b0);
      wait_k(1 + 2 * 8'h40);
      reset = 1'b0;
      @(posedge clock);
      #2;
      check("abort_halt", cpuHalt, 0);
      check("abort_active", dmaActive, 0);
      check("abort_bus_addr", busAddress, 16'h8123);
      check("abort_bus_rw", busRw, 1);
      drive(16'h4014, 8'h05, 1'b0);
      wait_tick();
      drive(16'h0000, 8'h00, 1'b1);
      reset = 1'b1;
      repeat (3) @(posedge clock);
      #2;
      check("reset_wins_active", dmaActive, 0);
      start_dma(8'h02, 1'b0);
      wait_idle();
      check("restart_halt_ticks", halt_ticks, 513);
      check("restart_oam_count", oam_q.size(), 256);
      check("restart_first_byte", oam_q[0], 8'hA5);

      // non-trigger traffic
      for (int i = 0; i < 3; i++) begin
         drive(16'h4014, 8'h02, 1'b1);
         wait_tick();
         drive(16'h4015, 8'h02, 1'b0);
         wait_tick();
      end
      #10;
      check("nontrig_active", dmaActive, 0);
      check("nontrig_bus_addr", busAddress, 16'h4015);
      check("nontrig_bus_rw", busRw, 0);

      // page FF reads FF00-FFFF without page carry
      start_dma(8'hFF, 1'b1);
      wait_idle();
      check("pff_halt_ticks", halt_ticks, 514);
      check("pff_oam_count", oam_q.size(), 256);
      check("pff_byte0", oam_q[0], 8'hA6);
      check("pff_byte255", oam_q[255], 8'h59);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
